// File: rtl/hexuart_if.sv
// Event input bundle for hexuart_logger: one prefix, value and strobe per channel.
interface hexuart_if #(
    parameter int NCHAN     = 2,
    parameter int VALUEBITS = 32
);
    logic [NCHAN*8-1:0]         ch_prefix;
    logic [NCHAN*VALUEBITS-1:0] ch_value;
    logic [NCHAN-1:0]           ch_valid;

    modport master (output ch_prefix, ch_value, ch_valid);
    modport slave  (input  ch_prefix, ch_value, ch_valid);
endinterface

// File: rtl/hexuart_logger.sv
// Multi-channel hex logger: per-channel pending slots, priority push into a FIFO,
// and an 8N1 serializer emitting "<prefix><hex digits>\n\r" per event.
module hexuart_logger #(
    parameter int CLKFREQ       = 50000000,
    parameter int BAUDRATE      = 115200,
    parameter int SAMPLECLK     = CLKFREQ / BAUDRATE,
    parameter int NCHAN         = 2,
    parameter int VALUEBITS     = 32,
    parameter int QUEUEADDRBITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    hexuart_if.slave               ch,
    output logic                   tx,
    output logic                   busy,
    output logic [QUEUEADDRBITS:0] queue_level,
    output logic [15:0]            drop_cnt
);
    localparam int ND     = VALUEBITS / 4;
    localparam int NCHARS = ND + 3;
    localparam int EW     = 8 + VALUEBITS;
    localparam int DEPTH  = 2 ** QUEUEADDRBITS;
    localparam int CIW    = $clog2(NCHARS);
    localparam int CW     = $clog2(SAMPLECLK);
    localparam int WW     = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [QUEUEADDRBITS:0] FULL_LVL = (QUEUEADDRBITS+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    logic [EW-1:0]              pend_data_r [NCHAN];
    logic [NCHAN-1:0]           pend_v_r;
    logic [EW-1:0]              mem_r [DEPTH];
    logic [QUEUEADDRBITS-1:0]   wr_ptr_r, rd_ptr_r;
    logic [QUEUEADDRBITS:0]     level_r;
    logic [15:0]                drop_r, drop_next_s;
    logic [16:0]                drop_sum_s;
    logic [3:0]                 drop_add_s;
    logic [WW-1:0]              win_s;
    logic                       win_v_s, push_s, pop_s;
    state_t                     state_r, state_s;
    logic [CW-1:0]              cnt_r;
    logic [2:0]                 bit_idx_r;
    logic [CIW-1:0]             char_idx_r;
    logic [7:0]                 char_r, char_sel_s;
    logic [3:0]                 nib_s;
    logic [EW-1:0]              frame_r;
    logic                       tx_r, tx_s, bit_done_s, last_char_s;

    assign bit_done_s  = (cnt_r == CW'(SAMPLECLK - 1));
    assign last_char_s = (char_idx_r == CIW'(NCHARS - 1));
    // A frame can also be popped straight out of the last stop bit so frames run back to back.
    assign pop_s = (level_r != '0) &&
                   ((state_r == S_IDLE) || ((state_r == S_STOP) && bit_done_s && last_char_s));

    // Lowest-index pending channel wins; a full FIFO still accepts a push when it pops.
    always_comb begin
        win_s      = '0;
        drop_add_s = 4'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            win_s = pend_v_r[i] ? WW'(i) : win_s;
        end
        win_v_s = |pend_v_r;
        push_s  = win_v_s && ((level_r != FULL_LVL) || pop_s);
        for (int k = 0; k < NCHAN; k++) begin
            drop_add_s = drop_add_s +
                4'(ch.ch_valid[k] && pend_v_r[k] && !(push_s && (win_s == WW'(k))));
        end
        drop_sum_s  = {1'b0, drop_r} + {13'd0, drop_add_s};
        drop_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // Pending slots, FIFO pointers/level and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v_r <= '0;
            for (int k = 0; k < NCHAN; k++) pend_data_r[k] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            drop_r   <= 16'd0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (ch.ch_valid[k]) begin
                    pend_data_r[k] <= {ch.ch_prefix[8*k +: 8], ch.ch_value[VALUEBITS*k +: VALUEBITS]};
                    pend_v_r[k]    <= 1'b1;
                end else if (push_s && (win_s == WW'(k))) begin
                    pend_v_r[k] <= 1'b0;
                end
            end
            if (push_s) wr_ptr_r <= wr_ptr_r + QUEUEADDRBITS'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + QUEUEADDRBITS'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (QUEUEADDRBITS+1)'(1);
                2'b01:   level_r <= level_r - (QUEUEADDRBITS+1)'(1);
                default: level_r <= level_r;
            endcase
            drop_r <= drop_next_s;
        end
    end

    // FIFO storage; the pushed entry is the slot content from before any same-cycle capture.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= pend_data_r[win_s];
    end

    // Character selection: prefix, MSB-first hex digits, LF, CR.
    always_comb begin
        nib_s = 4'd0;
        for (int i = 0; i < ND; i++) begin
            nib_s = (char_idx_r == CIW'(i + 1)) ? frame_r[4*(ND-1-i) +: 4] : nib_s;
        end
        if (char_idx_r == '0) begin
            char_sel_s = frame_r[EW-1 -: 8];
        end else if (char_idx_r == CIW'(NCHARS - 2)) begin
            char_sel_s = 8'h0A;
        end else if (char_idx_r == CIW'(NCHARS - 1)) begin
            char_sel_s = 8'h0D;
        end else begin
            char_sel_s = nibble_to_ascii(nib_s);
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Serializer next state and line level.
    always_comb begin
        state_s = state_r;
        tx_s    = 1'b1;
        case (state_r)
            S_IDLE:  state_s = pop_s ? S_LOAD : S_IDLE;
            S_LOAD:  state_s = S_START;
            S_START: begin
                tx_s    = 1'b0;
                state_s = bit_done_s ? S_DATA : S_START;
            end
            S_DATA: begin
                tx_s    = char_r[bit_idx_r];
                state_s = (bit_done_s && (bit_idx_r == 3'd7)) ? S_STOP : S_DATA;
            end
            S_STOP: begin
                if (bit_done_s) begin
                    state_s = (!last_char_s || (level_r != '0)) ? S_LOAD : S_IDLE;
                end else begin
                    state_s = S_STOP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Serializer datapath: bit timer, bit/char indices, current frame and registered tx.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            char_idx_r <= '0;
            char_r     <= 8'hFF;
            frame_r    <= '0;
            tx_r       <= 1'b1;
        end else begin
            tx_r <= tx_s;
            if (pop_s) begin
                frame_r    <= mem_r[rd_ptr_r];
                char_idx_r <= '0;
            end else if ((state_r == S_STOP) && bit_done_s && !last_char_s) begin
                char_idx_r <= char_idx_r + CIW'(1);
            end
            if (state_r == S_LOAD) char_r <= char_sel_s;
            if (state_r inside {S_START, S_DATA, S_STOP}) cnt_r <= bit_done_s ? '0 : cnt_r + CW'(1);
            else                                          cnt_r <= '0;
            if (state_r == S_START)                   bit_idx_r <= 3'd0;
            else if ((state_r == S_DATA) && bit_done_s) bit_idx_r <= bit_idx_r + 3'd1;
        end
    end

    assign tx          = tx_r;
    assign busy        = (state_r != S_IDLE) || (level_r != '0);
    assign queue_level = level_r;
    assign drop_cnt    = drop_r;
endmodule

// File: tb/tb_hexuart_logger.sv
// Scoreboard bench: stimulus pushes expected characters, per-DUT UART receivers pop and compare.
module tb_hexuart_logger;
    localparam int SC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    hexuart_if #(.NCHAN(2), .VALUEBITS(32)) if_a ();
    hexuart_if #(.NCHAN(2), .VALUEBITS(32)) if_b ();
    hexuart_if #(.NCHAN(2), .VALUEBITS(12)) if_c ();

    logic        tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
    logic [4:0]  ql_a, ql_c;
    logic [2:0]  ql_b;
    logic [15:0] dr_a, dr_b, dr_c;
    logic [2:0]  tx_w, busy_w;
    assign tx_w   = {tx_c, tx_b, tx_a};
    assign busy_w = {busy_c, busy_b, busy_a};

    hexuart_logger #(.SAMPLECLK(SC), .NCHAN(2), .VALUEBITS(32), .QUEUEADDRBITS(4)) dut_a (
        .clk(clk), .reset(reset), .ch(if_a), .tx(tx_a), .busy(busy_a),
        .queue_level(ql_a), .drop_cnt(dr_a));
    hexuart_logger #(.SAMPLECLK(SC), .NCHAN(2), .VALUEBITS(32), .QUEUEADDRBITS(2)) dut_b (
        .clk(clk), .reset(reset), .ch(if_b), .tx(tx_b), .busy(busy_b),
        .queue_level(ql_b), .drop_cnt(dr_b));
    hexuart_logger #(.SAMPLECLK(SC), .NCHAN(2), .VALUEBITS(12), .QUEUEADDRBITS(4)) dut_c (
        .clk(clk), .reset(reset), .ch(if_c), .tx(tx_c), .busy(busy_c),
        .queue_level(ql_c), .drop_cnt(dr_c));

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [3][$];
    int         rx_cnt [3];
    logic       abort [3];
    int         peak_b = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic exp_frame(input int g, input logic [7:0] p, input logic [63:0] v, input int nd);
        exp_q[g].push_back(p);
        for (int i = nd - 1; i >= 0; i--) exp_q[g].push_back(hex_char(v[4*i +: 4]));
        exp_q[g].push_back(8'h0A);
        exp_q[g].push_back(8'h0D);
    endtask

    task automatic drv_a(input logic [1:0] vld, input logic [7:0] p0, p1, input logic [31:0] v0, v1);
        @(posedge clk); #1;
        if_a.ch_valid = vld; if_a.ch_prefix = {p1, p0}; if_a.ch_value = {v1, v0};
    endtask
    task automatic drv_b(input logic [1:0] vld, input logic [7:0] p0, p1, input logic [31:0] v0, v1);
        @(posedge clk); #1;
        if_b.ch_valid = vld; if_b.ch_prefix = {p1, p0}; if_b.ch_value = {v1, v0};
    endtask
    task automatic drv_c(input logic [1:0] vld, input logic [7:0] p0, input logic [11:0] v0);
        @(posedge clk); #1;
        if_c.ch_valid = vld; if_c.ch_prefix = {8'h00, p0}; if_c.ch_value = {12'h000, v0};
    endtask

    task automatic wait_idle(input int g, input string nm);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy_w[g] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_busy_fall"}, 64'(busy_w[g]), 64'd0);
        check({nm, "_chars_left"}, 64'(exp_q[g].size()), 64'd0);
    endtask

    // UART receivers: sample mid-bit on the falling clock edge.
    for (genvar g = 0; g < 3; g++) begin : g_rx
        logic [7:0] c;
        logic       sb;
        always begin
            @(negedge clk);
            if (tx_w[g] === 1'b0) begin
                repeat (SC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (SC) @(negedge clk);
                    c[i] = tx_w[g];
                end
                repeat (SC) @(negedge clk);
                sb = tx_w[g];
                if (!abort[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected[%0d]: actual=%0h required=none", g, c);
                    end else begin
                        check($sformatf("rx_char[%0d]", g), 64'(c), 64'(exp_q[g].pop_front()));
                    end
                    check($sformatf("rx_stop[%0d]", g), 64'(sb), 64'd1);
                    rx_cnt[g]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ql_b > peak_b) peak_b <= int'(ql_b);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int base, n, lows;
        for (int g = 0; g < 3; g++) begin
            rx_cnt[g] = 0;
            abort[g]  = 1'b0;
        end
        if_a.ch_valid = 2'b00; if_a.ch_prefix = '0; if_a.ch_value = '0;
        if_b.ch_valid = 2'b00; if_b.ch_prefix = '0; if_b.ch_value = '0;
        if_c.ch_valid = 2'b00; if_c.ch_prefix = '0; if_c.ch_value = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tx", 64'(tx_a), 64'd1);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_level", 64'(ql_a), 64'd0);
        check("rst_drop", 64'(dr_a), 64'd0);
        check("rst_tx_b", 64'(tx_b), 64'd1);
        check("rst_tx_c", 64'(tx_c), 64'd1);

        // Single event on ch0
        exp_frame(0, 8'h64, 64'h0FFF0001, 8);
        drv_a(2'b01, 8'h64, 8'h00, 32'h0FFF0001, 32'h0);
        drv_a(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        wait_idle(0, "t1");
        check("t1_drop", 64'(dr_a), 64'd0);

        // Simultaneous events: ch0 first
        exp_frame(0, 8'h69, 64'h80000000, 8);
        exp_frame(0, 8'h64, 64'h00000480, 8);
        drv_a(2'b11, 8'h69, 8'h64, 32'h80000000, 32'h00000480);
        drv_a(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        wait_idle(0, "t2");
        check("t2_drop", 64'(dr_a), 64'd0);

        // Three back-to-back strobes on both channels: ch1 overwritten twice
        exp_frame(0, 8'h61, 64'h1, 8);
        exp_frame(0, 8'h61, 64'h2, 8);
        exp_frame(0, 8'h61, 64'h3, 8);
        exp_frame(0, 8'h62, 64'hB2, 8);
        drv_a(2'b11, 8'h61, 8'h62, 32'h1, 32'hB0);
        drv_a(2'b11, 8'h61, 8'h62, 32'h2, 32'hB1);
        drv_a(2'b11, 8'h61, 8'h62, 32'h3, 32'hB2);
        drv_a(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        wait_idle(0, "t3");
        check("t3_drop", 64'(dr_a), 64'd2);

        // Depth-4 FIFO filled while the serializer is busy
        exp_frame(1, 8'h78, 64'h99, 8);
        for (int k = 0; k < 6; k++) begin
            if (k != 4) exp_frame(1, 8'h65, 64'(32'h10 + k), 8);
        end
        drv_b(2'b10, 8'h00, 8'h78, 32'h0, 32'h99);
        drv_b(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            drv_b(2'b01, 8'h65, 8'h00, 32'h10 + k, 32'h0);
            drv_b(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        end
        repeat (2) @(negedge clk);
        check("t4_level_full", 64'(ql_b), 64'd4);
        check("t4_drop", 64'(dr_b), 64'd1);
        wait_idle(1, "t4");
        check("t4_peak", 64'(peak_b), 64'd4);
        check("t4_drop_end", 64'(dr_b), 64'd1);

        // 12-bit values
        exp_frame(2, 8'h68, 64'hAB3, 3);
        drv_c(2'b01, 8'h68, 12'hAB3);
        drv_c(2'b00, 8'h00, 12'h000);
        wait_idle(2, "t5");
        check("t5_drop", 64'(dr_c), 64'd0);

        // Reset during the third character
        exp_q[0].push_back(8'h72);
        exp_q[0].push_back(8'h31);
        base = rx_cnt[0];
        drv_a(2'b01, 8'h72, 8'h00, 32'h12345678, 32'h0);
        drv_a(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        n = 0;
        while (rx_cnt[0] < base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_two_chars", 64'(rx_cnt[0] - base), 64'd2);
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_third_start", 64'(tx_a), 64'd0);
        repeat (10) @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t6_tx", 64'(tx_a), 64'd1);
        check("t6_level", 64'(ql_a), 64'd0);
        check("t6_drop", 64'(dr_a), 64'd0);
        check("t6_busy", 64'(busy_a), 64'd0);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        check("t6_quiet", 64'(lows), 64'd0);
        abort[0] = 1'b0;
        exp_frame(0, 8'h7A, 64'hCAFE0000, 8);
        drv_a(2'b01, 8'h7A, 8'h00, 32'hCAFE0000, 32'h0);
        drv_a(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        wait_idle(0, "t6_recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
